// File: rtl/mul_resp_if.sv
// Payload types and the requester-facing bundle for the mulit/mulot multiplier port.
// muli carries requests in; gnt, mulo and done carry the response back.
package mul_resp_pkg;
  localparam int unsigned OP_W   = 27;
  localparam int unsigned PROD_W = 54;

  typedef struct packed {
    logic              en;
    logic [OP_W-1:0]   req_in_1;
    logic [OP_W-1:0]   req_in_2;
  } mulit_t;

  typedef struct packed {
    logic [PROD_W-1:0] out;
  } mulot_t;
endpackage

interface mul_resp_if #(parameter int unsigned NREQ = 2);
  import mul_resp_pkg::*;

  mulit_t            muli [NREQ];
  logic [NREQ-1:0]   gnt;
  mulot_t            mulo [NREQ];
  logic [NREQ-1:0]   done;

  modport master (output muli, input gnt, mulo, done);
  modport slave  (input muli, output gnt, mulo, done);
endinterface

// File: rtl/mul_resp.sv
// Round-robin arbiter feeding one shared pipelined 27x27 unsigned multiplier;
// each product lands in the granted requester's mulo register with a done pulse.
module mul_resp
  import mul_resp_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned LAT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  mul_resp_if.slave  bus,
  input  logic       flush,
  output logic       busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gid;
  logic [IDW-1:0]    idx;
  logic              found;

  logic              iss_vld;
  logic [IDW-1:0]    iss_id;
  logic [PROD_W-1:0] iss_prod;

  logic              fin_vld;
  logic [IDW-1:0]    fin_id;
  logic [PROD_W-1:0] fin_prod;
  logic              stage_busy;

  logic [NREQ-1:0]   done_q;
  logic [PROD_W-1:0] out_q [NREQ];

  // Rotating-priority search starting at ptr; no grant under reset or flush.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IDW'((32'(ptr) + off) % NREQ);
      if (!found && bus.muli[idx].en) begin
        found = 1'b1;
        gid   = idx;
      end
    end
    if (!reset || flush) found = 1'b0;
  end

  always_comb begin
    bus.gnt = '0;
    if (found) bus.gnt[gid] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
    end
  end

  // Product is formed at issue; the stage registers below give retiming room.
  assign iss_vld  = found;
  assign iss_id   = gid;
  assign iss_prod = PROD_W'(bus.muli[gid].req_in_1) * PROD_W'(bus.muli[gid].req_in_2);

  if (LAT == 1) begin : g_nopipe
    assign fin_vld    = iss_vld;
    assign fin_id     = iss_id;
    assign fin_prod   = iss_prod;
    assign stage_busy = 1'b0;
  end else begin : g_pipe
    logic [LAT-2:0] stg_vld;

    for (genvar k = 0; k < LAT - 1; k++) begin : g_stg
      logic              vld;
      logic [IDW-1:0]    id;
      logic [PROD_W-1:0] prod;
      logic              in_vld;
      logic [IDW-1:0]    in_id;
      logic [PROD_W-1:0] in_prod;

      if (k == 0) begin : g_src
        assign in_vld  = iss_vld;
        assign in_id   = iss_id;
        assign in_prod = iss_prod;
      end else begin : g_src
        assign in_vld  = g_stg[k-1].vld;
        assign in_id   = g_stg[k-1].id;
        assign in_prod = g_stg[k-1].prod;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld  <= 1'b0;
          id   <= '0;
          prod <= '0;
        end else begin
          vld  <= in_vld & ~flush;
          id   <= in_id;
          prod <= in_prod;
        end
      end

      assign stg_vld[k] = vld;
    end

    assign fin_vld    = g_stg[LAT-2].vld;
    assign fin_id     = g_stg[LAT-2].id;
    assign fin_prod   = g_stg[LAT-2].prod;
    assign stage_busy = |stg_vld;
  end

  // Final stage: per-requester result register and one-cycle completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= '0;
      out_q  <= '{default: '0};
    end else begin
      done_q <= '0;
      if (fin_vld && !flush) begin
        done_q[fin_id] <= 1'b1;
        out_q[fin_id]  <= fin_prod;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_out
    assign bus.mulo[i].out = out_q[i];
  end

  assign bus.done = done_q;
  assign busy     = stage_busy | (|done_q);

endmodule

// File: tb/tb_mul_resp.sv
// Randomized and directed stimulus for mul_resp, scored against a queue-based
// reference model of grants, completions, flush and reset.
module tb_mul_resp;
  import mul_resp_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned LAT  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  mul_resp_if #(.NREQ(NREQ)) bus();

  mul_resp #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .flush (flush),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              id;
    longint unsigned prod;
    int              gcyc;
  } exp_t;

  exp_t            q[$];
  longint unsigned exp_mulo [NREQ];
  int              mptr = 0;
  int              last_g = -1;
  int              tests = 0;
  int              fails = 0;

  logic            en_r [NREQ];
  logic [26:0]     a_r  [NREQ];
  logic [26:0]     b_r  [NREQ];

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [26:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 27'h0;
      1:       return 27'h7FFFFFF;
      default: return 27'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) bus.muli[i] = {en_r[i], a_r[i], b_r[i]};
  endtask

  task automatic set_req(input int i, input logic [26:0] a, input logic [26:0] b);
    en_r[i] = 1'b1;
    a_r[i]  = a;
    b_r[i]  = b;
  endtask

  // Reference arbiter: first requester in rotation from the model pointer wins.
  task automatic model_gnt();
    logic [NREQ-1:0] eg;
    eg     = '0;
    last_g = -1;
    if (reset && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mptr + k) % NREQ;
        if (last_g < 0 && en_r[i]) last_g = i;
      end
    end
    if (last_g >= 0) begin
      eg[last_g] = 1'b1;
      q.push_back('{last_g, 64'(a_r[last_g]) * 64'(b_r[last_g]), cyc});
      mptr = (last_g + 1) % NREQ;
    end
    check("gnt", 64'(bus.gnt), 64'(eg));
  endtask

  // Drop every operation that had not yet completed when flush was seen.
  task automatic purge(input int fc);
    exp_t keep[$];
    foreach (q[j]) if (q[j].gcyc <= fc - int'(LAT)) keep.push_back(q[j]);
    q = keep;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < NREQ; i++) exp_mulo[i] = 0;
    mptr = 0;
  endtask

  task automatic tick();
    logic f;
    int   fc;
    drive();
    @(negedge clk);
    model_gnt();
    f  = flush;
    fc = cyc;
    @(posedge clk);
    if (f) purge(fc);
    #1;
    if (last_g >= 0) en_r[last_g] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic refill(input int pct);
    for (int i = 0; i < NREQ; i++)
      if (!en_r[i] && $urandom_range(0, 99) < pct) set_req(i, rnd_op(), rnd_op());
  endtask

  // Monitor: compare completions, result registers and busy every cycle.
  always @(negedge clk) begin
    logic [NREQ-1:0] ed;
    logic            eb;
    eb = 1'b0;
    foreach (q[j]) if (q[j].gcyc >= cyc - int'(LAT) && q[j].gcyc < cyc) eb = 1'b1;
    ed = '0;
    if (q.size() > 0 && q[0].gcyc == cyc - int'(LAT)) begin
      ed[q[0].id]        = 1'b1;
      exp_mulo[q[0].id]  = q[0].prod;
      void'(q.pop_front());
    end
    check("done", 64'(bus.done), 64'(ed));
    for (int i = 0; i < NREQ; i++) check("mulo", 64'(bus.mulo[i].out), exp_mulo[i]);
    check("busy", 64'(busy), 64'(eb));
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      en_r[i] = 1'b0; a_r[i] = '0; b_r[i] = '0; exp_mulo[i] = 0;
    end
    drive();
    @(posedge clk);
    #1;

    // Held in reset with random requests: nothing may be granted.
    assert_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
      en_r[$urandom_range(0, NREQ-1)] = 1'b0;
      tick();
    end

    // Contention from reset release: grants must alternate starting at 0.
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_op(), rnd_op());
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      refill(100);
    end
    for (int i = 0; i < NREQ; i++) en_r[i] = 1'b0;
    idle(LAT + 2);

    // Single small operation.
    set_req(0, 27'd3, 27'd5);
    tick();
    idle(LAT + 2);

    // Operand extremes.
    set_req(0, 27'h7FFFFFF, 27'h7FFFFFF);
    tick();
    set_req(1, 27'h0, 27'h7FFFFFF);
    tick();
    idle(LAT + 2);

    // Flush kills two in-flight operations; a request held during flush waits.
    set_req(0, 27'd2, 27'd2);
    tick();
    set_req(1, 27'd3, 27'd3);
    tick();
    flush = 1'b1;
    set_req(0, 27'd9, 27'd11);
    tick();
    flush = 1'b0;
    idle(LAT + 2);

    // Reset in the cycle after a grant loses the operation.
    set_req(1, rnd_op(), rnd_op());
    tick();
    assert_reset();
    idle(2);
    reset = 1'b1;
    idle(1);
    set_req(0, 27'd7, 27'd6);
    tick();
    idle(LAT + 2);

    // Random traffic with sporadic flushes.
    for (int k = 0; k < 300; k++) begin
      refill(60);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    for (int i = 0; i < NREQ; i++) en_r[i] = 1'b0;
    idle(LAT + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
